bv_decode_pack: RTL and testbench
=================================

Name: bv_decode_pack

Overview:
- Final stage of the BV-FHE decryption path.
- Consumes the stream of noisy plaintext coefficients (c0 + c1·s mod q) from the polynomial multiply/accumulate stage, one coefficient per accepted beat.
- Threshold-decodes each coefficient to one message bit and packs N bits into the recovered_message word.
- Asserts done when all N coefficients are collected; this drives the system final_done.

Parameters:
- N, 512, number of coefficients and message bits; must be ≥ 2.
- Q_WIDTH, 16, coefficient width in bits.
- Q, 12289, ciphertext modulus. Must satisfy 4 ≤ Q < 2^Q_WIDTH.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a new decode pass.
- coef_in  input  Q_WIDTH  residue for coefficient index cnt.
- coef_valid  input  1  coef_in is valid this cycle.
- coef_ready  output  1  block accepts coef_in this cycle.
- recovered_message  output  N  decoded bits; bit i comes from coefficient i.
- done  output  1  level; high once all N coefficients are decoded.
- busy  output  1  high while in COLLECT.
- range_err  output  1  sticky; a coefficient ≥ Q was received during the current pass.

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-pass):
  - state = IDLE, cnt = 0.
  - recovered_message = 0, done = 0, busy = 0, coef_ready = 0, range_err = 0.
- Thresholds are compile-time constants: LO = floor(Q/4), HI = floor(3Q/4). For the default Q: LO = 3072, HI = 9216.
- Decode of accepted value c:
  - If c ≥ Q: set range_err, then use c' = c − Q. Only one subtraction; the width is sufficient because c < 2^Q_WIDTH < 2Q is not required, the single subtraction is the defined behaviour.
  - Otherwise c' = c.
  - bit = 1 iff LO < c' ≤ HI; else 0.
- States: IDLE, COLLECT, DONE. All outputs are registered except coef_ready and busy, which decode the current state.
- IDLE:
  - coef_ready = 0.
  - On start: cnt ← 0, recovered_message ← 0, range_err ← 0, done ← 0, go to COLLECT.
- COLLECT:
  - coef_ready = 1, busy = 1.
  - A beat is accepted when coef_valid && coef_ready. On accept: recovered_message[cnt] ← bit, cnt ← cnt + 1.
  - Accepting with cnt = N−1: cnt wraps to 0, done ← 1, go to DONE.
  - Latency: done is high in the cycle after the N-th accept, with the final bit already visible.
  - coef_valid low: no change; gaps of any length are allowed.
  - start is ignored here; no restart and no clearing.
- DONE:
  - coef_ready = 0. done and recovered_message hold.
  - start begins a new pass exactly as from IDLE: done drops the cycle after start, and the message clears.
  - coef_valid beats are not accepted and have no effect.
- Simultaneous rst and start: rst wins.
- cnt width is clog2(N); it never exceeds N−1.

Test Plan:
- Reset, start, 512 beats of coef_in = 6144 with continuous valid → done high on the cycle after beat 512. recovered_message = all ones (512'hFFFF…F). range_err = 0. busy low in DONE.
- Alternate coefficients 6144, 0, 6144, 0, … → recovered_message = 512'h5555…5 (bit0 = 1).
- Boundary values at indices 0–5: 3072, 3073, 9216, 9217, 12288, 0; all remaining coefficients 6144.
  - Required bits[5:0] = 6'b000110; all other bits = 1.
- Index 7 = 12289 (≥ Q), decoded as 0 → range_err = 1 and bit 7 = 0.
  - A subsequent start clears range_err and the message.
- Random coef_valid gaps (~40% idle) plus a start pulse injected mid-COLLECT → start is ignored; the message matches the gap-free run; done follows exactly 512 accepts.
- Assert rst after 200 beats → next cycle: all outputs 0, state IDLE, coef_ready = 0.
  - A fresh start then a full 512-beat pass completes correctly.

Source files
------------

// File: rtl/bv_decode_pack.sv
// bv_decode_pack: threshold-decodes N noisy BV-FHE plaintext coefficients
// (one per accepted beat) into message bits and packs them into one word.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   start             pulse; begins a decode pass from IDLE or DONE
//   coef_in           residue for coefficient index cnt
//   coef_valid        coef_in valid this cycle
//   coef_ready        block accepts coef_in (high only in COLLECT)
//   recovered_message decoded bits, bit i from coefficient i
//   done              level, high once all N coefficients are decoded
//   busy              high while collecting
//   range_err         sticky; a coefficient >= Q arrived this pass
module bv_decode_pack #(
    parameter int N       = 512,
    parameter int Q_WIDTH = 16,
    parameter int Q       = 12289
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [Q_WIDTH-1:0] coef_in,
    input  logic               coef_valid,
    output logic               coef_ready,
    output logic [N-1:0]       recovered_message,
    output logic               done,
    output logic               busy,
    output logic               range_err
);

    localparam int CW = $clog2(N);
    localparam int LO = Q / 4;
    localparam int HI = (3 * Q) / 4;

    localparam logic [Q_WIDTH-1:0] Q_C  = Q_WIDTH'(Q);
    localparam logic [Q_WIDTH-1:0] LO_C = Q_WIDTH'(LO);
    localparam logic [Q_WIDTH-1:0] HI_C = Q_WIDTH'(HI);
    localparam logic [CW-1:0]      LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [Q_WIDTH-1:0] coef_adj;
    logic               coef_oor;
    logic               coef_bit;
    logic               accept;
    logic               last_beat;

    // Single conditional reduction: inputs >= 2Q stay out of range
    // after one subtraction and are decoded as they come out.
    always_comb begin
        coef_oor = (coef_in >= Q_C);
        coef_adj = coef_oor ? (coef_in - Q_C) : coef_in;
        coef_bit = (coef_adj > LO_C) && (coef_adj <= HI_C);
    end

    assign accept    = coef_valid && coef_ready;
    assign last_beat = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        coef_ready = 1'b0;
        busy       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                coef_ready = 1'b1;
                busy       = 1'b1;
                if (coef_valid && last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_COLLECT;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt               <= '0;
            recovered_message <= '0;
            done              <= 1'b0;
            range_err         <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt               <= '0;
                        recovered_message <= '0;
                        done              <= 1'b0;
                        range_err         <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        recovered_message[cnt] <= coef_bit;
                        if (coef_oor) begin
                            range_err <= 1'b1;
                        end
                        if (last_beat) begin
                            cnt  <= '0;
                            done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bv_decode_pack.sv
// tb_bv_decode_pack: randomized self-checking bench for bv_decode_pack,
// compared against an integer-arithmetic model of the threshold decode.
module tb_bv_decode_pack;

    localparam int N  = 512;
    localparam int QW = 16;
    localparam int Q  = 12289;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [QW-1:0] coef_in;
    logic          coef_valid;
    logic          coef_ready;
    logic [N-1:0]  recovered_message;
    logic          done;
    logic          busy;
    logic          range_err;

    int total = 0;
    int bad   = 0;

    bv_decode_pack #(.N(N), .Q_WIDTH(QW), .Q(Q)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .coef_in           (coef_in),
        .coef_valid        (coef_valid),
        .coef_ready        (coef_ready),
        .recovered_message (recovered_message),
        .done              (done),
        .busy              (busy),
        .range_err         (range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] got,
                       input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_bit(input int c);
        int v;
        v = c;
        if (v >= Q) v = v - Q;
        return (v > Q / 4) && (v <= (3 * Q) / 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int mode, input int i);
        int r;
        r = 6144;
        case (mode)
            1: r = (i % 2 == 0) ? 6144 : 0;
            2: begin
                case (i)
                    0: r = 3072;
                    1: r = 3073;
                    2: r = 9216;
                    3: r = 9217;
                    4: r = 12288;
                    5: r = 0;
                    default: r = 6144;
                endcase
            end
            3: r = (i == 7) ? 12289 : 6144;
            4: r = int'($urandom_range(0, 65535));
            default: r = 6144;
        endcase
        return r;
    endfunction

    // mode: stimulus pattern; gap: idle-cycle percent; inj: beat index
    // at which start is also pulsed; abort: beat index to reset at (-1 none)
    task automatic run_pass(input int mode, input int gap, input int inj,
                            input int abort, input logic [N-1:0] want,
                            input logic want_re);
        logic [N-1:0] m;
        logic         re;
        int           c;
        m  = '0;
        re = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", N'(busy), N'(1'b1));
        chk("start_ready", N'(coef_ready), N'(1'b1));
        chk("start_done", N'(done), N'(1'b0));
        chk("start_msg", recovered_message, '0);
        chk("start_rerr", N'(range_err), N'(1'b0));
        for (int i = 0; i < N; i++) begin
            if (i == abort) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("abort_msg", recovered_message, '0);
                chk("abort_flags",
                    N'({done, busy, coef_ready, range_err}), '0);
                tick();
                chk("abort_idle_ready", N'(coef_ready), N'(1'b0));
                return;
            end
            while (int'($urandom_range(0, 99)) < gap) begin
                coef_valid = 1'b0;
                coef_in    = QW'($urandom);
                tick();
            end
            if (i == N - 1) begin
                chk("pre_last_done", N'(done), N'(1'b0));
            end
            if (i % 128 == 0) begin
                chk("beat_ready", N'(coef_ready), N'(1'b1));
            end
            c          = pick(mode, i);
            coef_in    = QW'(c);
            coef_valid = 1'b1;
            start      = (i == inj);
            m[i]       = ref_bit(c);
            if (c >= Q) re = 1'b1;
            tick();
            coef_valid = 1'b0;
            start      = 1'b0;
        end
        chk("done", N'(done), N'(1'b1));
        chk("msg_model", recovered_message, m);
        chk("msg_known", recovered_message, want);
        chk("rerr", N'(range_err), N'(re));
        chk("rerr_known", N'(range_err), N'(want_re));
        chk("done_busy", N'(busy), N'(1'b0));
        chk("done_ready", N'(coef_ready), N'(1'b0));
        for (int k = 0; k < 4; k++) begin
            coef_valid = 1'b1;
            coef_in    = QW'($urandom);
            tick();
        end
        coef_valid = 1'b0;
        chk("hold_msg", recovered_message, m);
        chk("hold_done", N'(done), N'(1'b1));
    endtask

    logic [N-1:0] ones;
    logic [N-1:0] alt;
    logic [N-1:0] bnd;
    logic [N-1:0] rng;
    logic [N-1:0] dontcare;

    initial begin
        ones = '1;
        for (int i = 0; i < N; i++) alt[i] = (i % 2 == 0);
        bnd = ones;
        bnd[5:0] = 6'b000110;
        rng = ones;
        rng[7] = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        coef_in    = '0;
        coef_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_msg", recovered_message, '0);
        chk("rst_flags", N'({done, busy, coef_ready, range_err}), '0);
        coef_valid = 1'b1;
        tick();
        coef_valid = 1'b0;
        chk("idle_ready", N'(coef_ready), N'(1'b0));

        run_pass(0, 0, -1, -1, ones, 1'b0);
        run_pass(1, 0, -1, -1, alt, 1'b0);
        run_pass(2, 0, -1, -1, bnd, 1'b0);
        run_pass(3, 0, -1, -1, rng, 1'b1);
        run_pass(0, 40, 100, -1, ones, 1'b0);
        run_pass(0, 0, -1, 200, ones, 1'b0);
        run_pass(1, 30, 300, -1, alt, 1'b0);

        // random values: model decides expected bits, known-value check
        // is made redundant by passing the model's own result below
        dontcare = '0;
        begin
            logic [N-1:0] m;
            logic         re;
            int           vals[N];
            re = 1'b0;
            for (int i = 0; i < N; i++) begin
                vals[i] = int'($urandom_range(0, 65535));
                m[i] = ref_bit(vals[i]);
                if (vals[i] >= Q) re = 1'b1;
            end
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < N; i++) begin
                while (int'($urandom_range(0, 99)) < 40) begin
                    coef_valid = 1'b0;
                    tick();
                end
                coef_valid = 1'b1;
                coef_in    = QW'(vals[i]);
                tick();
                coef_valid = 1'b0;
            end
            chk("rand_done", N'(done), N'(1'b1));
            chk("rand_msg", recovered_message, m);
            chk("rand_rerr", N'(range_err), N'(re));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
